// File: rtl/weight_mem_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | weight_mem_resp                                                          |
// | PE weight-SRAM read responder with a burst loader that fills the array.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module weight_mem_resp #(
    parameter int W_DATA_WIDTH = 16,
    parameter int W_ADDR_WIDTH = 10,
    parameter int W_DEPTH      = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_mem_cen,
    input  logic                    w_mem_wen,
    input  logic [W_ADDR_WIDTH-1:0] w_mem_addr,
    output logic [W_DATA_WIDTH-1:0] w_mem_rdata,
    output logic                    w_mem_rvalid,
    input  logic                    load_start,
    input  logic [W_ADDR_WIDTH-1:0] load_base,
    input  logic [W_ADDR_WIDTH:0]   load_len,
    input  logic                    load_valid,
    input  logic [W_DATA_WIDTH-1:0] load_data,
    output logic                    load_ready,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    wr_err
);

    localparam logic [W_ADDR_WIDTH:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [W_ADDR_WIDTH-1:0] base_q, base_d;
    logic [W_ADDR_WIDTH:0]   len_q, len_d;
    logic [W_ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [W_DATA_WIDTH-1:0] mem_q [W_DEPTH];
    logic [W_DATA_WIDTH-1:0] rdata_q;
    logic                    rvalid_q;
    logic                    wr_err_q;

    logic                    rd_req;
    logic                    bad_wr;
    logic                    accept;
    logic                    last_word;
    logic [W_ADDR_WIDTH-1:0] wr_addr;

    assign rd_req    = ~w_mem_cen & w_mem_wen;
    assign bad_wr    = ~w_mem_cen & ~w_mem_wen;
    assign accept    = load_valid & load_ready;
    assign last_word = (cnt_q == (len_q - CNT_ONE));
    // Truncation to the address width gives the wrap past the top of the array.
    assign wr_addr   = base_q + cnt_q[W_ADDR_WIDTH-1:0];

    assign w_mem_rdata  = rdata_q;
    assign w_mem_rvalid = rvalid_q;
    assign wr_err       = wr_err_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        // Any read request (cen low) stalls the loader so read and write never collide.
        load_ready = (state_q == ST_LOAD) & w_mem_cen;
        load_busy  = (state_q != ST_IDLE);
        load_done  = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    base_d  = load_base;
                    len_d   = load_len;
                    cnt_d   = '0;
                    state_d = (load_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (last_word) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rd_req;
            if (rd_req) begin
                rdata_q <= mem_q[w_mem_addr];
            end
            if (bad_wr) begin
                wr_err_q <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; words written before an abort survive.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem_q[wr_addr] <= load_data;
        end
    end

endmodule
`default_nettype wire
